// File: rtl/mult_sweep_scorer.sv
// mult_sweep_scorer: walks every {op_a,op_b} pair of a combinational
// multiplier under test, compares its product against the exact product and
// reports mismatch count, first failing index and a pass flag.
// Optional feature macro: MULT_SWEEP_ERRMAP_EN adds a per-vector err_map output.
module mult_sweep_scorer #(
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  input  logic [2*WIDTH-1:0]     dut_p,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH:0]       err_count,
  output logic [2*WIDTH-1:0]     first_err_idx,
`ifdef MULT_SWEEP_ERRMAP_EN
  output logic [(1<<(2*WIDTH))-1:0] err_map,
`endif
  output logic                   pass
);

  localparam int PW = 2 * WIDTH;
  localparam int N  = 1 << PW;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_idx;
  logic [PW:0]     r_err_count;
  logic [PW-1:0]   r_first;
  logic [PW-1:0]   w_exp;
  logic            w_mis;
  logic            w_last;
  logic            w_accept;
`ifdef MULT_SWEEP_ERRMAP_EN
  logic [N-1:0]    r_err_map;
`endif

  // Exact product of the presented vector and the mismatch/acceptance decode.
  always_comb begin
    w_exp    = {{WIDTH{1'b0}}, r_idx[PW-1:WIDTH]} * {{WIDTH{1'b0}}, r_idx[WIDTH-1:0]};
    w_mis    = (r_state == S_SWEEP) && (dut_p != w_exp);
    w_last   = (r_idx == {PW{1'b1}});
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start is only honoured outside SWEEP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_SWEEP;
      S_SWEEP: if (w_last) w_next = S_DONE;
      S_DONE:  if (start)  w_next = S_SWEEP;
      default:             w_next = S_IDLE;
    endcase
  end

  // Outputs. The index wraps back to 0 after the last vector, so the
  // operands sit at 0 in IDLE/DONE without extra muxing.
  always_comb begin
    busy          = (r_state == S_SWEEP);
    done          = (r_state == S_DONE);
    op_a          = r_idx[PW-1:WIDTH];
    op_b          = r_idx[WIDTH-1:0];
    err_count     = r_err_count;
    first_err_idx = r_first;
    pass          = done && (r_err_count == '0);
  end

  // Sweep datapath: index advance, mismatch counting, first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_first     <= '0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_first     <= '0;
    end else if (r_state == S_SWEEP) begin
      r_idx <= r_idx + 1'b1;
      if (w_mis) begin
        if (r_err_count != (PW+1)'(N)) r_err_count <= r_err_count + 1'b1;
        if (r_err_count == '0)         r_first     <= r_idx;
      end
    end
  end

`ifdef MULT_SWEEP_ERRMAP_EN
  // Per-vector failure map, cleared on sweep start and held in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_err_map <= '0;
    else if (w_accept) r_err_map <= '0;
    else if (w_mis)  r_err_map[r_idx] <= 1'b1;
  end

  assign err_map = r_err_map;
`endif

endmodule

// File: tb/tb_mult_sweep_scorer.sv
// Scoreboard bench for mult_sweep_scorer: a table-driven multiplier model
// (exact, stuck-zero, LSB-zero, random faults) feeds the WIDTH=2 instance;
// expectations are computed from the table with plain arithmetic and queued,
// and a negedge monitor pops them when done rises. A WIDTH=3 instance with an
// exact multiplier covers the larger sweep.
module tb_mult_sweep_scorer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, start3;
  logic [1:0]  op_a, op_b;
  logic [3:0]  dut_p;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic [2:0]  op_a3, op_b3;
  logic [5:0]  dut_p3;
  logic        busy3, done3, pass3;
  logic [6:0]  err_count3;
  logic [5:0]  first_err_idx3;
`ifdef MULT_SWEEP_ERRMAP_EN
  logic [15:0] err_map;
  logic [63:0] err_map3;
`endif

  logic [3:0]  tbl [16];

  always #5 clk = ~clk;

  assign dut_p  = tbl[{op_a, op_b}];
  assign dut_p3 = {3'b000, op_a3} * {3'b000, op_b3};

  mult_sweep_scorer #(.WIDTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .dut_p(dut_p), .busy(busy), .done(done), .err_count(err_count),
    .first_err_idx(first_err_idx),
`ifdef MULT_SWEEP_ERRMAP_EN
    .err_map(err_map),
`endif
    .pass(pass));

  mult_sweep_scorer #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op_a(op_a3), .op_b(op_b3),
    .dut_p(dut_p3), .busy(busy3), .done(done3), .err_count(err_count3),
    .first_err_idx(first_err_idx3),
`ifdef MULT_SWEEP_ERRMAP_EN
    .err_map(err_map3),
`endif
    .pass(pass3));

  typedef struct {
    int          cnt;
    int          first;
    logic [15:0] map;
    int          s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference: score the whole table directly from the exact products.
  function automatic exp_t model();
    exp_t e;
    e.cnt = 0; e.first = 0; e.map = '0; e.s = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(tbl[i]) != (i / 4) * (i % 4)) begin
        if (e.cnt == 0) e.first = i;
        e.cnt++;
        e.map[i] = 1'b1;
      end
    end
    return e;
  endfunction

  // 0 exact, 1 stuck-at-zero, 2 LSB forced zero, 3 random faults
  task automatic set_tbl(input int mode);
    for (int i = 0; i < N; i++) begin
      int p;
      p = (i / 4) * (i % 4);
      case (mode)
        0: tbl[i] = 4'(p);
        1: tbl[i] = 4'd0;
        2: tbl[i] = 4'(p) & 4'b1110;
        default: tbl[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(p);
      endcase
    end
  endtask

  // Record the expectation at the edge that samples start.
  task automatic push_at_edge();
    exp_t e;
    @(posedge clk);
    #1;
    e   = model();
    e.s = cyc;
    q.push_back(e);
  endtask

  task automatic issue();
    @(negedge clk);
    start = 1'b1;
    push_at_edge();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  // Monitor: operand order while sweeping, busy/done exclusivity, and the
  // scoreboard pop on every rising done.
  logic pb = 1'b0, pd = 1'b0;
  int   exp_idx = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pb      <= 1'b0;
      pd      <= 1'b0;
      exp_idx <= 0;
    end else begin
      if (busy || done) chk("busy_done_excl", int'(busy && done), 0);
      if (busy) begin
        if (!pb) chk("err_cleared_on_entry", int'(err_count), 0);
        chk("vector_order", int'({op_a, op_b}), pb ? exp_idx : 0);
        exp_idx <= pb ? exp_idx + 1 : 1;
      end else if (!done) begin
        chk("ops_zero_idle", int'({op_a, op_b}), 0);
      end
      if (done && !pd) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_latency", cyc - e.s, N);
          chk("err_count", int'(err_count), e.cnt);
          chk("pass", int'(pass), int'(e.cnt == 0));
          if (e.cnt != 0) chk("first_err_idx", int'(first_err_idx), e.first);
`ifdef MULT_SWEEP_ERRMAP_EN
          chk("err_map", int'(err_map), int'(e.map));
`endif
        end
      end
      pb <= busy;
      pd <= done;
    end
  end

  logic [5:0] last3 = '0;
  always @(negedge clk) if (busy3) last3 <= {op_a3, op_b3};

  task automatic chk_reset_vals();
    chk("rst_ops", int'({op_a, op_b}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_first_err_idx", int'(first_err_idx), 0);
    chk("rst_pass", int'(pass), 0);
`ifdef MULT_SWEEP_ERRMAP_EN
    chk("rst_err_map", int'(err_map), 0);
`endif
  endtask

  initial begin
    int s3, n3;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    set_tbl(0);
    repeat (2) @(negedge clk);
    chk_reset_vals();
    #2 rst_n = 1'b1;

    // Directed: exact, stuck-zero, LSB-zero.
    for (int m = 0; m < 3; m++) begin
      set_tbl(m);
      issue();
      wait_done();
      @(negedge clk);
    end

    // Fixed values for the LSB-zero case.
    chk("lsb0_err_count", int'(err_count), 4);
    chk("lsb0_first_err_idx", int'(first_err_idx), 5);
`ifdef MULT_SWEEP_ERRMAP_EN
    chk("lsb0_err_map", int'(err_map), 16'hA0A0);
`endif

    // Reset mid-sweep, then a fresh sweep.
    set_tbl(1);
    issue();
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_tbl(2);
    issue();
    wait_done();
    @(negedge clk);

    // Randomised fault tables.
    for (int r = 0; r < 6; r++) begin
      set_tbl(3);
      issue();
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start held high: back-to-back sweeps with one-cycle DONE.
    set_tbl(1);
    @(negedge clk);
    start = 1'b1;
    push_at_edge();
    for (int k = 0; k < 2; k++) begin
      wait_done();
      push_at_edge();
    end
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // WIDTH=3 exact sweep.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 s3 = cyc;
    start3 = 1'b0;
    n3 = 0;
    while (!done3 && n3 < 200) begin
      @(negedge clk);
      n3++;
    end
    chk("w3_done", int'(done3), 1);
    chk("w3_latency", cyc - s3, 64);
    chk("w3_err_count", int'(err_count3), 0);
    chk("w3_pass", int'(pass3), 1);
    chk("w3_last_vector", int'(last3), 63);

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sweep_scorer.md
# mult_sweep_scorer

Exhaustive scoring stage that sits directly downstream of a candidate small-width multiplier, such as the agent-generated partial-product multipliers. On `start` it walks every operand pair, drives each pair to the multiplier under evaluation, and compares the returned product against the exact product. It reports the mismatch count, the first failing vector and a pass flag, which the training flow consumes as the correctness term of the reward.

## Interface
Parameters:
- `WIDTH`, default 2: operand width of the evaluated multiplier; legal range 2..4. Product width is 2*WIDTH and the vector count N is 2^(2*WIDTH).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: sweep request; sampled only in IDLE or DONE.
- `op_a`  out  WIDTH: A operand driven to the multiplier.
- `op_b`  out  WIDTH: B operand driven to the multiplier.
- `dut_p`  in  2*WIDTH: multiplier product. The multiplier is purely combinational from `op_a`/`op_b`.
- `busy`  out  1: high while sweeping.
- `done`  out  1: high from sweep completion until the next accepted `start` or reset.
- `err_count`  out  2*WIDTH+1: number of mismatching vectors.
- `first_err_idx`  out  2*WIDTH: index {a,b} of the first mismatch; valid only when `err_count` is nonzero.
- `pass`  out  1: `done` and `err_count`==0.

## Operation
- States are IDLE, SWEEP and DONE.
  - IDLE, with `start` high: go to SWEEP. Clear the index, `err_count` and `first_err_idx`.
  - SWEEP: every cycle, the vector index idx = {op_a, op_b} is presented. `op_a` holds the MSBs, so the order is (0,0),(0,1)…(0,2^W-1),(1,0)…
    - Expected product = op_a*op_b, computed unsigned at 2*WIDTH bits. It cannot overflow.
    - On a mismatch, `err_count` increments. If this is the first mismatch, `first_err_idx` latches idx.
    - If idx == N-1, go to DONE after scoring that vector. Otherwise idx increments.
  - DONE: `done` is high and the results are held. `start` high re-enters SWEEP with everything cleared, as from IDLE.
- `start` is ignored during SWEEP. There is no abort input.
- `op_a`/`op_b` are driven straight from the index register. In IDLE and DONE they hold 0.
- `err_count` saturates at N, which cannot be exceeded by construction. Its width allows the value N.
- Reset values: state IDLE, `op_a`=0, `op_b`=0, `busy`=0, `done`=0, `err_count`=0, `first_err_idx`=0, `pass`=0.
- Reset mid-sweep: all state clears immediately and asynchronously. No partial result remains visible.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1: `busy`=1 and vector 0 is on `op_a`/`op_b`.
- Vector k is on the outputs in cycle k+1. Comparison is combinational within that same cycle, and the counter update is registered at the end of the cycle.
- Cycle N+1: `busy`=0, `done`=1, and `err_count`, `first_err_idx` and `pass` are final. For WIDTH=2 this is cycle 17.
- `done` and `busy` are never high together.
- Back-to-back sweeps: `start` sampled in DONE in cycle M gives `done`=0 and `busy`=1 in cycle M+1.

## Configuration
- `MULT_SWEEP_ERRMAP_EN` defined:
  - Adds output `err_map` [N-1:0]. Bit idx is set when vector idx mismatched.
  - `err_map` is cleared at sweep start and on reset, and held in DONE.
- `MULT_SWEEP_ERRMAP_EN` undefined:
  - The port and register are absent.
  - All other behaviour is identical.

## Test plan
- Exact multiplier model (dut_p = op_a*op_b), WIDTH=2, `start` pulse:
  - `done` rises in cycle 17.
  - `err_count`=0 and `pass`=1.
- Stuck-at-zero model (dut_p=0), WIDTH=2:
  - `err_count`=9.
  - `first_err_idx`=4'b0101 (A=1, B=1).
  - `pass`=0.
- LSB-forced-zero model (dut_p = {prod[3:1],1'b0}):
  - `err_count`=4, `first_err_idx`=4'b0101.
  - With `MULT_SWEEP_ERRMAP_EN`: `err_map`=16'hA0A0 (vectors 5, 7, 13, 15).
- Reset and restart:
  - `rst_n` pulsed low in cycle 8 of a sweep: all outputs return to reset values at once.
  - A fresh `start` gives the correct result 16 cycles later.
- `start` held high continuously:
  - `start` is ignored during SWEEP.
  - Sweeps repeat back-to-back. Each DONE lasts exactly 1 cycle, and results clear on re-entry.
- Exact model with WIDTH=3:
  - `done` arrives in cycle 65.
  - `err_count`=0, `pass`=1.
  - The last vector driven is op_a=7, op_b=7 in cycle 64.
